// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the sparsity-aware matrix-vector accelerator feeder.
//   PKG_DIM, PKG_DATA_W, PKG_IDX_W, PKG_FIFO_DEPTH : default geometry
//   sparse_entry_t : one buffered nonzero element {row, col, value}
//   pack_state_t   : packer sequencing states {IDLE, SCAN, DRAIN, DONE}
// The entry struct is sized from the package defaults, so the packer and FIFO
// are expected to be built with DIM/DATA_W equal to PKG_DIM/PKG_DATA_W.
// -----------------------------------------------------------------------------
package mvm_pkg;

   localparam int PKG_DIM        = 4;
   localparam int PKG_DATA_W     = 8;
   localparam int PKG_IDX_W      = $clog2(PKG_DIM);
   localparam int PKG_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [PKG_IDX_W-1:0]  row;
      logic [PKG_IDX_W-1:0]  col;
      logic [PKG_DATA_W-1:0] value;
   } sparse_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } pack_state_t;

endpackage

// File: rtl/sparse_fifo.sv
// -----------------------------------------------------------------------------
// sparse_fifo
// Synchronous show-ahead FIFO of sparse_entry_t. The head entry is visible on
// 'head' whenever 'empty' is low; 'pop' consumes it at the next rising edge.
// Flags are registered: a pop does not clear 'full' until the following cycle.
// Ports:
//   clk, rst (async active-high)
//   push, push_data : write request (ignored while full)
//   pop             : read request (ignored while empty)
//   head            : oldest entry (show-ahead)
//   full, empty     : registered occupancy flags
// -----------------------------------------------------------------------------
module sparse_fifo
   import mvm_pkg::*;
#(
   parameter int DEPTH = PKG_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  sparse_entry_t push_data,
   input  logic          pop,
   output sparse_entry_t head,
   output logic          full,
   output logic          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   sparse_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_next_s;
   logic              full_r;
   logic              empty_r;
   logic              push_en_s;
   logic              pop_en_s;

   assign push_en_s = push && !full_r;
   assign pop_en_s  = pop && !empty_r;

   // Next occupancy; simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_next_s = count_r;
      case ({push_en_s, pop_en_s})
         2'b10:   count_next_s = count_r + {{PTR_W{1'b0}}, 1'b1};
         2'b01:   count_next_s = count_r - {{PTR_W{1'b0}}, 1'b1};
         default: count_next_s = count_r;
      endcase
   end

   // Entry storage; cleared on reset so the head reads as zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_en_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, count and registered flags (power-of-two depth wraps naturally).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_en_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_en_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == DEPTH_C);
         empty_r <= (count_next_s == {(PTR_W+1){1'b0}});
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/sparse_entry_packer.sv
// -----------------------------------------------------------------------------
// sparse_entry_packer
// Accepts a dense DIM x DIM matrix as a row-major element stream, drops zero
// elements and buffers each nonzero one as a {row, col, value} entry for the
// accelerator's fetch interface. After the last entry of a matrix has been
// taken, done_list pulses for one cycle.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   dense_valid/dense_data   : input element stream (row-major)
//   dense_ready              : element accepted when dense_valid && dense_ready
//   fetch_ready              : accelerator takes an entry when out_valid is high
//   out_valid/out_row/out_col/out_value : show-ahead entry presentation
//   done_list                : one-cycle pulse, matrix fully delivered
//   nnz_count                : nonzero count of the current matrix
// Build option:
//   SPARSE_NNZ_COUNT_EN - when defined, nnz_count counts pushes per matrix;
//                         otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module sparse_entry_packer
   import mvm_pkg::*;
#(
   parameter  int DIM        = PKG_DIM,
   parameter  int DATA_W     = PKG_DATA_W,
   parameter  int FIFO_DEPTH = PKG_FIFO_DEPTH,
   localparam int IDX_W      = $clog2(DIM),
   localparam int CNT_W      = $clog2(DIM*DIM) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dense_valid,
   input  logic [DATA_W-1:0] dense_data,
   output logic              dense_ready,
   input  logic              fetch_ready,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic [DATA_W-1:0] out_value,
   output logic              done_list,
   output logic [CNT_W-1:0]  nnz_count
);

   pack_state_t       state_r;
   pack_state_t       state_next_s;
   // Row index in the upper half, column in the lower half: a plain increment
   // wraps col DIM-1 -> 0 and carries into row.
   logic [2*IDX_W-1:0] idx_r;
   logic               ready_en_r;
   logic               dense_ready_s;
   logic               accept_s;
   logic               push_s;
   logic               pop_s;
   logic               last_elem_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   sparse_entry_t      push_entry_s;
   sparse_entry_t      head_s;

   assign last_elem_s = (idx_r == {(2*IDX_W){1'b1}});

   // Input readiness: only while collecting, FIFO not full (registered flag),
   // and never before the first clock edge after reset.
   always_comb begin
      dense_ready_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_SCAN: dense_ready_s = ready_en_r && !fifo_full_s;
         default:          dense_ready_s = 1'b0;
      endcase
   end

   assign accept_s = dense_valid && dense_ready_s;
   assign push_s   = accept_s && (dense_data != {DATA_W{1'b0}});
   assign pop_s    = fetch_ready && !fifo_empty_s;

   assign push_entry_s.row   = idx_r[2*IDX_W-1:IDX_W];
   assign push_entry_s.col   = idx_r[IDX_W-1:0];
   assign push_entry_s.value = dense_data;

   sparse_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Sequencing: collect elements, drain the FIFO, then signal completion.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = last_elem_s ? ST_DRAIN : ST_SCAN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (accept_s && last_elem_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_SCAN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Ready enable: holds dense_ready low while in reset and releases it on the
   // first clock edge afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

   // Matrix position: advances on every accepted element, cleared at DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r <= {(2*IDX_W){1'b0}};
      end else if (state_r == ST_DONE) begin
         idx_r <= {(2*IDX_W){1'b0}};
      end else if (accept_s) begin
         idx_r <= idx_r + 1'b1;
      end
   end

`ifdef SPARSE_NNZ_COUNT_EN
   logic [CNT_W-1:0] nnz_r;

   // Nonzero counter: restarts on a matrix's first accept, then counts pushes;
   // the total is held from DONE until the next matrix begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nnz_r <= {CNT_W{1'b0}};
      end else if (accept_s && (state_r == ST_IDLE)) begin
         nnz_r <= {{(CNT_W-1){1'b0}}, push_s};
      end else if (push_s) begin
         nnz_r <= nnz_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign nnz_count = nnz_r;
`else
   assign nnz_count = {CNT_W{1'b0}};
`endif

   assign dense_ready = dense_ready_s;
   assign out_valid   = !fifo_empty_s;
   assign out_row     = head_s.row;
   assign out_col     = head_s.col;
   assign out_value   = head_s.value;
   assign done_list   = (state_r == ST_DONE);

endmodule

// File: tb/tb_sparse_entry_packer.sv
// -----------------------------------------------------------------------------
// tb_sparse_entry_packer
// Directed and randomized checks of sparse_entry_packer against a queue-based
// reference: the expected entry list is derived from the matrix contents, and
// occupancy/phase are tracked from the handshake rules.
// -----------------------------------------------------------------------------
module tb_sparse_entry_packer;

   localparam int DIM        = 4;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int IDX_W      = 2;
   localparam int CNT_W      = 5;
   localparam int N          = DIM * DIM;

   typedef struct {
      int row;
      int col;
      int val;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              dense_valid;
   logic [DATA_W-1:0] dense_data;
   logic              dense_ready;
   logic              fetch_ready;
   logic              out_valid;
   logic [IDX_W-1:0]  out_row;
   logic [IDX_W-1:0]  out_col;
   logic [DATA_W-1:0] out_value;
   logic              done_list;
   logic [CNT_W-1:0]  nnz_count;

   int   checks = 0;
   int   errors = 0;
   ent_t expq[$];
   int   occ;
   int   nnz_model;
   logic [7:0] mat [N];

   always #5 clk = ~clk;

   sparse_entry_packer dut (
      .clk         (clk),
      .rst         (rst),
      .dense_valid (dense_valid),
      .dense_data  (dense_data),
      .dense_ready (dense_ready),
      .fetch_ready (fetch_ready),
      .out_valid   (out_valid),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_value   (out_value),
      .done_list   (done_list),
      .nnz_count   (nnz_count)
   );

   function automatic int exp_nnz(input int v);
`ifdef SPARSE_NNZ_COUNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Feeds one matrix and checks every cycle against the reference.
   task automatic run_matrix(input int vpct, input int fpct, input int stall, output int done_cyc);
      int   i = 0;
      int   phase = 0;          // 0 collecting, 1 draining, 2 done pulse
      bit   finished = 0;
      bit   prev_hold = 0;
      logic [IDX_W-1:0]  pr = '0;
      logic [IDX_W-1:0]  pc = '0;
      logic [DATA_W-1:0] pv = '0;
      logic exp_ready, exp_valid, accept, take, push;
      done_cyc = -1;
      expq.delete();
      occ = 0;
      for (int k = 0; k < N; k++) begin
         if (mat[k] != 8'd0) expq.push_back('{k / DIM, k % DIM, int'(mat[k])});
      end
      for (int c = 0; c < 3000 && !finished; c++) begin
         dense_valid = (i < N) && ($urandom_range(99) < vpct);
         dense_data  = dense_valid ? mat[(i < N) ? i : 0] : 8'($urandom);
         fetch_ready = (c >= stall) && ($urandom_range(99) < fpct);
         exp_ready   = (phase == 0) && (occ < FIFO_DEPTH);
         exp_valid   = (occ > 0);
         chk("dense_ready", dense_ready, exp_ready);
         chk("out_valid", out_valid, exp_valid);
         chk("done_list", done_list, phase == 2);
         chk("nnz_count", nnz_count, exp_nnz(nnz_model));
         if (exp_valid && expq.size() > 0) begin
            chk("out_row", out_row, expq[0].row);
            chk("out_col", out_col, expq[0].col);
            chk("out_value", out_value, expq[0].val);
         end
         if (prev_hold) begin
            chk("stall_row", out_row, pr);
            chk("stall_col", out_col, pc);
            chk("stall_value", out_value, pv);
         end
         prev_hold = exp_valid && !fetch_ready;
         pr = out_row;
         pc = out_col;
         pv = out_value;
         accept = dense_valid && exp_ready;
         take   = exp_valid && fetch_ready;
         push   = accept && (mat[(i < N) ? i : 0] != 8'd0);
         if (accept) begin
            if (i == 0) nnz_model = 0;
            if (push) nnz_model++;
         end
         if (take) void'(expq.pop_front());
         if (phase == 2) begin
            finished = 1;
            done_cyc = c;
         end else if (phase == 1 && occ == 0) begin
            phase = 2;
         end else if (phase == 0 && accept && i == N - 1) begin
            phase = 1;
         end
         occ = occ + int'(push) - int'(take);
         if (accept) i++;
         @(posedge clk);
         @(negedge clk);
      end
      dense_valid = 1'b0;
      fetch_ready = 1'b0;
      if (!finished) chk("timeout", 32'd0, 32'd1);
      chk("entries_left", expq.size(), 32'd0);
   endtask

   initial begin
      int dc;
      rst         = 1'b1;
      dense_valid = 1'b0;
      dense_data  = 8'd0;
      fetch_ready = 1'b0;
      nnz_model   = 0;

      // Reset values.
      #1;
      chk("rst_dense_ready", dense_ready, 32'd0);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_out_row", out_row, 32'd0);
      chk("rst_out_col", out_col, 32'd0);
      chk("rst_out_value", out_value, 32'd0);
      chk("rst_done_list", done_list, 32'd0);
      chk("rst_nnz_count", nnz_count, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_before_edge", dense_ready, 32'd0);
      @(negedge clk);
      chk("ready_after_edge", dense_ready, 32'd1);

      // Diagonal matrix.
      for (int k = 0; k < N; k++) mat[k] = (k / DIM == k % DIM) ? 8'(k / DIM + 1) : 8'd0;
      run_matrix(100, 100, 0, dc);
      chk("diag_nnz_hold", nnz_count, exp_nnz(4));

      // All-zero matrix: done_list exactly at cycle 17.
      for (int k = 0; k < N; k++) mat[k] = 8'd0;
      run_matrix(100, 100, 0, dc);
      chk("zero_done_cycle", dc, 32'd17);
      chk("zero_nnz_hold", nnz_count, exp_nnz(0));

      // Dense 1..16 with fetch stalled for a while.
      for (int k = 0; k < N; k++) mat[k] = 8'(k + 1);
      run_matrix(100, 100, 12, dc);
      chk("dense_nnz_hold", nnz_count, exp_nnz(16));

      // Randomized 50%-sparse matrices with random gaps and stalls.
      for (int m = 0; m < 4; m++) begin
         for (int k = 0; k < N; k++) mat[k] = ($urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'd0;
         run_matrix(70, 60, 0, dc);
      end

      // Reset in the middle of a matrix: 7 accepts, 2 entries buffered.
      for (int k = 0; k < N; k++) mat[k] = 8'd0;
      mat[1] = 8'd5;
      mat[6] = 8'd9;
      fetch_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         dense_valid = 1'b1;
         dense_data  = mat[k];
         @(posedge clk);
         @(negedge clk);
      end
      dense_valid = 1'b0;
      chk("pre_rst_out_valid", out_valid, 32'd1);
      chk("pre_rst_out_value", out_value, 32'd5);
      chk("pre_rst_out_col", out_col, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 32'd0);
      chk("async_rst_dense_ready", dense_ready, 32'd0);
      chk("async_rst_done_list", done_list, 32'd0);
      chk("async_rst_nnz", nnz_count, 32'd0);
      @(negedge clk);
      chk("in_rst_done_list", done_list, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      nnz_model = 0;
      for (int k = 0; k < N; k++) mat[k] = ($urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'd0;
      mat[0] = 8'd7;
      run_matrix(80, 70, 0, dc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sparse_entry_packer.md
# sparse_entry_packer

Upstream feeder for the sparsity-aware matrix-vector accelerator. Accepts a dense DIM×DIM matrix as a row-major byte stream, drops zero elements, and buffers each nonzero element as a (row, column, value) entry. Entries are presented to the accelerator's fetch interface: value, row, column and a valid/sending strobe, gated by the accelerator's fetch-ready. After the last entry of a matrix has been taken, the block pulses the accelerator's done-list input.

## Interface
- DIM, 4: matrix dimension; power of two, ≥2; index width IDX_W = log2(DIM).
- DATA_W, 8: element width.
- FIFO_DEPTH, 4: entry buffer depth; power of two, ≥2.

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dense_valid  in  1  dense element present on dense_data.
- dense_data  in  DATA_W  dense element, row-major order.
- dense_ready  out  1  block can accept an element this cycle.
- fetch_ready  in  1  accelerator ready to take an entry (its FETCH_ready).
- out_valid  out  1  entry present (drives sending_CPU).
- out_row  out  IDX_W  entry row index.
- out_col  out  IDX_W  entry column index.
- out_value  out  DATA_W  entry value.
- done_list  out  1  one-cycle pulse: matrix fully delivered.
- nnz_count  out  log2(DIM*DIM)+1  nonzero count of the current matrix (see Configuration).

## Operation
- Input handshake: an element is accepted when dense_valid && dense_ready.
- Output handshake: an entry is taken when out_valid && fetch_ready. out_row, out_col and out_value are stable while out_valid=1 and fetch_ready=0.
- Position counters row/col start at (0,0). They advance on every accepted element, zero or not: col wraps DIM-1→0 and increments row.
- Accepted element ≠ 0 (any bit set): push {row, col, data} into the FIFO. Accepted element = 0: no push.
- FSM:
  - IDLE: dense_ready = !full. First accept → SCAN. If that accept is the final element (only for DIM=1, not allowed), the FSM goes to DRAIN.
  - SCAN: dense_ready = !full. Accepting element index DIM*DIM-1 → DRAIN.
  - DRAIN: dense_ready = 0. FIFO empty → DONE.
  - DONE: done_list = 1 for this single cycle; counters cleared → IDLE.
- dense_ready uses registered full only. A pop in the same cycle does not free space until the next cycle.
- Push and pop in the same cycle: the count is unchanged and both take effect.
- FIFO order is preserved; entries leave in row-major order.
- All-zero matrix: no out_valid; done_list is still pulsed.
- Reset: takes effect immediately and asynchronously. State goes to IDLE; FIFO is emptied; row/col and nnz_count are cleared; any partial matrix is discarded.
  - Reset values: dense_ready=0, out_valid=0, out_row=0, out_col=0, out_value=0, done_list=0, nnz_count=0.
  - dense_ready rises in the first cycle after rst deasserts.

## Timing
- Nonzero element accepted in cycle t → out_valid=1 in cycle t+1, provided the FIFO was empty (show-ahead, registered).
- Last element accepted at t → DRAIN at t+1.
- DONE in the first cycle of DRAIN that sees the FIFO empty, with empty registered; done_list is high that cycle.
- All-zero matrix, dense_valid held high: 16 accepts in cycles 0–15, DRAIN at 16, done_list at 17.
- Sustained throughput is one element per cycle while the FIFO is not full.

## Configuration
- SPARSE_NNZ_COUNT_EN defined: nnz_count increments on each push. It holds the total from DONE until the next matrix's first accept, then restarts from that element.
- Not defined: nnz_count is tied to 0 and no counter logic is built.

## Structure
- Package mvm_pkg holds:
  - DIM, DATA_W and IDX_W defaults;
  - typedef sparse_entry_t {row, col, value};
  - the FSM state enum {IDLE, SCAN, DRAIN, DONE}.
- Sub-module sparse_fifo: a synchronous show-ahead FIFO of sparse_entry_t with depth FIFO_DEPTH. It has full/empty flags and async active-high reset.

## Test plan
- Diagonal matrix [1,0,0,0 / 0,2,0,0 / 0,0,3,0 / 0,0,0,4], fetch_ready=1 → exactly 4 entries (0,0,1),(1,1,2),(2,2,3),(3,3,4), then one done_list pulse; nnz_count=4 with the macro.
- All-zero matrix, dense_valid=1 → out_valid never high; done_list high in cycle 17 only; nnz_count=0.
- Dense matrix of values 1..16, fetch_ready=0 → 4 accepts, then dense_ready=0 with the FIFO holding (0,0,1)…(0,3,4). Release fetch_ready → all 16 entries in row-major order, no loss or duplication; done_list pulsed once.
- Random fetch_ready and random dense_valid gaps on a 50%-sparse matrix → output sequence matches the reference model exactly; outputs stable while stalled.
- rst asserted after 7 accepts with 2 entries buffered → out_valid and dense_ready fall at once, no done_list. A following matrix starts at (0,0) and completes correctly.
- Build without SPARSE_NNZ_COUNT_EN, dense matrix → nnz_count stays 0, all other behaviour identical.
